// File: rtl/game_engine.sv
// Frame-tick game-state engine: snowball motion, four bouncing fireballs, hit/lives,
// invulnerability cooldown and win detection. All outputs are registers.
module game_engine #(
    parameter int FIRE_DIV = 2,
    parameter int CD_DIV   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic       btn_c,
    output logic [6:0] char_x,
    output logic [5:0] char_y,
    output logic [6:0] fire1_x,
    output logic [6:0] fire2_x,
    output logic [6:0] fire3_x,
    output logic [6:0] fire4_x,
    output logic [5:0] fire1_y,
    output logic [5:0] fire2_y,
    output logic [5:0] fire3_y,
    output logic [5:0] fire4_y,
    output logic [1:0] life,
    output logic       win,
    output logic       cooldown,
    output logic [2:0] cd_cnt,
    output logic       game_over
);
    localparam int FW = (FIRE_DIV > 1) ? $clog2(FIRE_DIV) : 1;
    localparam int CW = (CD_DIV > 1) ? $clog2(CD_DIV) : 1;

    // Fireballs 0..2 travel in x, fireball 3 travels in y; dir=1 means +1.
    localparam logic [6:0] FX0 [4] = '{7'd3, 7'd92, 7'd3, 7'd60};
    localparam logic [5:0] FY0 [4] = '{6'd21, 6'd37, 6'd53, 6'd14};
    localparam logic [3:0] FD0     = 4'b1101;

    typedef enum logic [2:0] {S_IDLE, S_PLAY, S_HIT, S_DEAD, S_WON} state_t;

    state_t        r_state;
    logic [6:0]    r_cx;
    logic [5:0]    r_cy;
    logic [6:0]    r_fx [4];
    logic [5:0]    r_fy [4];
    logic [3:0]    r_fdir;
    logic [1:0]    r_life;
    logic          r_win;
    logic          r_cd;
    logic [2:0]    r_cdcnt;
    logic          r_go;
    logic [FW-1:0] r_fdiv;
    logic [CW-1:0] r_cdiv;

    logic [6:0]    w_cx_nxt;
    logic [5:0]    w_cy_nxt;
    logic [6:0]    w_fx_nxt [4];
    logic [5:0]    w_fy_nxt [4];
    logic [3:0]    w_fdir_nxt;
    logic          w_fstep;
    logic          w_cd_step;
    logic          w_hit;
    logic          w_win;

    // Distances are taken at 8 bits so the subtraction never wraps.
    function automatic logic near(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] d;
        d = (a >= b) ? (a - b) : (b - a);
        return (d <= 8'd3);
    endfunction

    assign w_fstep   = (r_fdiv == FW'(FIRE_DIV - 1));
    assign w_cd_step = (r_cdiv == CW'(CD_DIV - 1));
    assign w_win     = (r_cx >= 7'd88) && (r_cy >= 6'd56);

    always_comb begin
        w_cx_nxt = r_cx;
        if (btn_r && !btn_l && r_cx < 7'd91)
            w_cx_nxt = r_cx + 7'd1;
        else if (btn_l && !btn_r && r_cx > 7'd4)
            w_cx_nxt = r_cx - 7'd1;
        w_cy_nxt = r_cy;
        if (btn_d && !btn_u && r_cy < 6'd59)
            w_cy_nxt = r_cy + 6'd1;
        else if (btn_u && !btn_d && r_cy > 6'd15)
            w_cy_nxt = r_cy - 6'd1;
    end

    always_comb begin
        w_hit = 1'b0;
        for (int k = 0; k < 4; k++)
            if (near({1'b0, r_cx}, {1'b0, r_fx[k]}) && near({2'b0, r_cy}, {2'b0, r_fy[k]}))
                w_hit = 1'b1;
    end

    // Reaching a bound while heading into it reflects: reverse and step one pixel back.
    always_comb begin
        w_fdir_nxt = r_fdir;
        for (int k = 0; k < 4; k++) begin
            w_fx_nxt[k] = r_fx[k];
            w_fy_nxt[k] = r_fy[k];
        end
        if (w_fstep) begin
            for (int k = 0; k < 3; k++) begin
                if (r_fdir[k]) begin
                    if (r_fx[k] >= 7'd92) begin
                        w_fx_nxt[k]   = 7'd91;
                        w_fdir_nxt[k] = 1'b0;
                    end else
                        w_fx_nxt[k] = r_fx[k] + 7'd1;
                end else if (r_fx[k] <= 7'd3) begin
                    w_fx_nxt[k]   = 7'd4;
                    w_fdir_nxt[k] = 1'b1;
                end else
                    w_fx_nxt[k] = r_fx[k] - 7'd1;
            end
            if (r_fdir[3]) begin
                if (r_fy[3] >= 6'd60) begin
                    w_fy_nxt[3]   = 6'd59;
                    w_fdir_nxt[3] = 1'b0;
                end else
                    w_fy_nxt[3] = r_fy[3] + 6'd1;
            end else if (r_fy[3] <= 6'd14) begin
                w_fy_nxt[3]   = 6'd15;
                w_fdir_nxt[3] = 1'b1;
            end else
                w_fy_nxt[3] = r_fy[3] - 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cx    <= 7'd4;
            r_cy    <= 6'd15;
            for (int k = 0; k < 4; k++) begin
                r_fx[k] <= FX0[k];
                r_fy[k] <= FY0[k];
            end
            r_fdir  <= FD0;
            r_life  <= 2'd3;
            r_win   <= 1'b0;
            r_cd    <= 1'b0;
            r_cdcnt <= 3'd0;
            r_go    <= 1'b0;
            r_fdiv  <= '0;
            r_cdiv  <= '0;
        end else if (tick) begin
            case (r_state)
                S_IDLE, S_DEAD, S_WON: begin
                    if (btn_c) begin
                        r_state <= S_PLAY;
                        r_cx    <= 7'd4;
                        r_cy    <= 6'd15;
                        for (int k = 0; k < 4; k++) begin
                            r_fx[k] <= FX0[k];
                            r_fy[k] <= FY0[k];
                        end
                        r_fdir  <= FD0;
                        r_life  <= 2'd3;
                        r_win   <= 1'b0;
                        r_cd    <= 1'b0;
                        r_cdcnt <= 3'd0;
                        r_go    <= 1'b0;
                        r_fdiv  <= '0;
                        r_cdiv  <= '0;
                    end
                end
                S_PLAY, S_HIT: begin
                    if (w_win) begin
                        r_state <= S_WON;
                        r_win   <= 1'b1;
                    end else if (r_state == S_PLAY && w_hit && r_life < 2'd2) begin
                        r_state <= S_DEAD;
                        r_life  <= 2'd0;
                        r_go    <= 1'b1;
                        r_cd    <= 1'b0;
                    end else begin
                        r_cx <= w_cx_nxt;
                        r_cy <= w_cy_nxt;
                        for (int k = 0; k < 4; k++) begin
                            r_fx[k] <= w_fx_nxt[k];
                            r_fy[k] <= w_fy_nxt[k];
                        end
                        r_fdir <= w_fdir_nxt;
                        r_fdiv <= w_fstep ? '0 : r_fdiv + 1'b1;
                        if (r_state == S_PLAY && w_hit) begin
                            r_state <= S_HIT;
                            r_life  <= r_life - 2'd1;
                            r_cd    <= 1'b1;
                            r_cdcnt <= 3'd7;
                            r_cdiv  <= '0;
                        end else if (r_state == S_HIT) begin
                            if (w_cd_step) begin
                                r_cdiv  <= '0;
                                r_cdcnt <= r_cdcnt - 3'd1;
                                if (r_cdcnt == 3'd1) begin
                                    r_cd    <= 1'b0;
                                    r_state <= S_PLAY;
                                end
                            end else
                                r_cdiv <= r_cdiv + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign char_x    = r_cx;
    assign char_y    = r_cy;
    assign fire1_x   = r_fx[0];
    assign fire2_x   = r_fx[1];
    assign fire3_x   = r_fx[2];
    assign fire4_x   = r_fx[3];
    assign fire1_y   = r_fy[0];
    assign fire2_y   = r_fy[1];
    assign fire3_y   = r_fy[2];
    assign fire4_y   = r_fy[3];
    assign life      = r_life;
    assign win       = r_win;
    assign cooldown  = r_cd;
    assign cd_cnt    = r_cdcnt;
    assign game_over = r_go;
endmodule

// File: tb/tb_game_engine.sv
// Bench for game_engine: directed scenarios plus random play, checked every tick
// against a frame-level reference model of the game rules.
module tb_game_engine;
    localparam int FIRE_DIV = 2;
    localparam int CD_DIV   = 4;
    localparam int M_IDLE = 0, M_PLAY = 1, M_HIT = 2, M_DEAD = 3, M_WON = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0, btn_c = 1'b0;
    logic [6:0] char_x, fire1_x, fire2_x, fire3_x, fire4_x;
    logic [5:0] char_y, fire1_y, fire2_y, fire3_y, fire4_y;
    logic [1:0] life;
    logic       win, cooldown, game_over;
    logic [2:0] cd_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state: m_fp is each fireball's moving coordinate, m_fv its velocity.
    int m_cx, m_cy, m_life, m_win, m_cd, m_cdcnt, m_go, m_mode, m_fcnt, m_ccnt;
    int m_fp [4];
    int m_fv [4];

    game_engine #(.FIRE_DIV(FIRE_DIV), .CD_DIV(CD_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick),
        .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d), .btn_c(btn_c),
        .char_x(char_x), .char_y(char_y),
        .fire1_x(fire1_x), .fire2_x(fire2_x), .fire3_x(fire3_x), .fire4_x(fire4_x),
        .fire1_y(fire1_y), .fire2_y(fire2_y), .fire3_y(fire3_y), .fire4_y(fire4_y),
        .life(life), .win(win), .cooldown(cooldown), .cd_cnt(cd_cnt), .game_over(game_over)
    );

    always #5 clk = ~clk;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int mfx(input int k);
        return (k < 3) ? m_fp[k] : 60;
    endfunction

    function automatic int mfy(input int k);
        case (k)
            0:       return 21;
            1:       return 37;
            2:       return 53;
            default: return m_fp[3];
        endcase
    endfunction

    function automatic bit danger(input int x, input int y);
        bit h = 1'b0;
        for (int k = 0; k < 4; k++)
            if (iabs(x - mfx(k)) <= 5 && iabs(y - mfy(k)) <= 5) h = 1'b1;
        return h;
    endfunction

    task automatic m_init();
        m_cx = 4; m_cy = 15;
        m_fp[0] = 3;  m_fv[0] = 1;
        m_fp[1] = 92; m_fv[1] = -1;
        m_fp[2] = 3;  m_fv[2] = 1;
        m_fp[3] = 14; m_fv[3] = 1;
        m_life = 3; m_win = 0; m_cd = 0; m_cdcnt = 0; m_go = 0;
        m_fcnt = 0; m_ccnt = 0;
    endtask

    task automatic m_step(input bit l, input bit r, input bit u, input bit d, input bit c);
        bit hit;
        int lo, hi, p;
        if (m_mode == M_IDLE || m_mode == M_DEAD || m_mode == M_WON) begin
            if (c) begin
                m_init();
                m_mode = M_PLAY;
            end
            return;
        end
        hit = 1'b0;
        for (int k = 0; k < 4; k++)
            if (iabs(m_cx - mfx(k)) <= 3 && iabs(m_cy - mfy(k)) <= 3) hit = 1'b1;
        if (m_cx >= 88 && m_cy >= 56) begin
            m_mode = M_WON;
            m_win  = 1;
            return;
        end
        if (m_mode == M_PLAY && hit && m_life == 1) begin
            m_life = 0; m_go = 1; m_cd = 0; m_mode = M_DEAD;
            return;
        end
        m_cx = m_cx + int'(r && !l) - int'(l && !r);
        m_cy = m_cy + int'(d && !u) - int'(u && !d);
        if (m_cx > 91) m_cx = 91;
        if (m_cx < 4)  m_cx = 4;
        if (m_cy > 59) m_cy = 59;
        if (m_cy < 15) m_cy = 15;
        m_fcnt++;
        if (m_fcnt == FIRE_DIV) begin
            m_fcnt = 0;
            for (int k = 0; k < 4; k++) begin
                lo = (k < 3) ? 3 : 14;
                hi = (k < 3) ? 92 : 60;
                p  = m_fp[k] + m_fv[k];
                if (p > hi) begin p = 2 * hi - p; m_fv[k] = -1; end
                else if (p < lo) begin p = 2 * lo - p; m_fv[k] = 1; end
                m_fp[k] = p;
            end
        end
        if (m_mode == M_PLAY && hit) begin
            m_life--; m_mode = M_HIT; m_cd = 1; m_cdcnt = 7; m_ccnt = 0;
        end else if (m_mode == M_HIT) begin
            m_ccnt++;
            if (m_ccnt == CD_DIV) begin
                m_ccnt = 0;
                m_cdcnt--;
                if (m_cdcnt == 0) begin
                    m_cd = 0;
                    m_mode = M_PLAY;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("char_x", 32'(char_x), m_cx);
        chk("char_y", 32'(char_y), m_cy);
        chk("fire1_x", 32'(fire1_x), mfx(0));
        chk("fire1_y", 32'(fire1_y), mfy(0));
        chk("fire2_x", 32'(fire2_x), mfx(1));
        chk("fire2_y", 32'(fire2_y), mfy(1));
        chk("fire3_x", 32'(fire3_x), mfx(2));
        chk("fire3_y", 32'(fire3_y), mfy(2));
        chk("fire4_x", 32'(fire4_x), mfx(3));
        chk("fire4_y", 32'(fire4_y), mfy(3));
        chk("life", 32'(life), m_life);
        chk("win", 32'(win), m_win);
        chk("cooldown", 32'(cooldown), m_cd);
        chk("cd_cnt", 32'(cd_cnt), m_cdcnt);
        chk("game_over", 32'(game_over), m_go);
    endtask

    task automatic do_tick(input bit l, input bit r, input bit u, input bit d, input bit c);
        @(negedge clk);
        btn_l = l; btn_r = r; btn_u = u; btn_d = d; btn_c = c;
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        btn_l = 1'b0; btn_r = 1'b0; btn_u = 1'b0; btn_d = 1'b0; btn_c = 1'b0;
        m_step(l, r, u, d, c);
        check_all();
    endtask

    // Buttons held but tick low: nothing may change.
    task automatic gap();
        @(negedge clk);
        btn_r = 1'b1; btn_d = 1'b1; btn_c = 1'b1;
        @(posedge clk);
        #1;
        btn_r = 1'b0; btn_d = 1'b0; btn_c = 1'b0;
        check_all();
    endtask

    // Asynchronous reset asserted between clock edges; init values must appear at once.
    task automatic reset_dut();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_char_x", 32'(char_x), 4);
        chk("rst_char_y", 32'(char_y), 15);
        chk("rst_life", 32'(life), 3);
        chk("rst_flags", 32'({win, cooldown, game_over}), 0);
        chk("rst_cd_cnt", 32'(cd_cnt), 0);
        chk("rst_fire2_x", 32'(fire2_x), 92);
        @(negedge clk);
        rst_n = 1'b1;
        m_init();
        m_mode = M_IDLE;
    endtask

    initial begin
        int lb;
        m_init();
        m_mode = M_IDLE;

        #12;
        chk("por_char_x", 32'(char_x), 4);
        chk("por_char_y", 32'(char_y), 15);
        chk("por_life", 32'(life), 3);
        chk("por_fire1_x", 32'(fire1_x), 3);
        chk("por_fire4_y", 32'(fire4_y), 14);
        chk("por_flags", 32'({win, cooldown, game_over}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (10) do_tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("idle_char_x", 32'(char_x), 4);
        chk("idle_fire1_x", 32'(fire1_x), 3);

        // Start, then stand still while the fireballs run to their bounds.
        do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 180; i++) begin
            do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 92)  chk("f4_top", 32'(fire4_y), 60);
            if (i == 94)  chk("f4_back", 32'(fire4_y), 59);
            if (i == 178) chk("f1_edge", 32'(fire1_x), 92);
        end
        chk("f1_back", 32'(fire1_x), 91);
        gap();
        gap();

        repeat (5) do_tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lr_cancel", 32'(char_x), 4);
        repeat (3) do_tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("u_clamp", 32'(char_y), 15);
        repeat (50) do_tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("d_clamp", 32'(char_y), 59);
        chk("d_life", 32'(life), 3);

        // Hit: step to y=18, fire1 at (4,21) overlaps on the fourth tick.
        reset_dut();
        do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) do_tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("hit_life", 32'(life), 2);
        chk("hit_cd", 32'(cooldown), 1);
        chk("hit_cdcnt", 32'(cd_cnt), 7);
        for (int i = 0; i < 27; i++) begin
            do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("cd_no_loss", 32'(life), 2);
        end
        chk("cd_last_cnt", 32'(cd_cnt), 1);
        chk("cd_last_flag", 32'(cooldown), 1);
        do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("cd_end_flag", 32'(cooldown), 0);
        chk("cd_end_cnt", 32'(cd_cnt), 0);

        for (int n = 0; n < 1200 && !(m_life == 1 && m_mode == M_PLAY); n++)
            do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("second_hit", 32'(life), 1);
        repeat (3) do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_dut();
        repeat (10) do_tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("post_rst_x", 32'(char_x), 4);
        chk("post_rst_y", 32'(char_y), 15);
        chk("post_rst_f1", 32'(fire1_x), 3);

        // Death: three separate passes of fire1.
        do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) do_tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 2500 && m_go == 0; n++)
            do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("dead_go", 32'(game_over), 1);
        chk("dead_life", 32'(life), 0);
        chk("dead_cd", 32'(cooldown), 0);
        repeat (10) do_tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("dead_frozen", 32'(life), 0);
        do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("restart_x", 32'(char_x), 4);
        chk("restart_life", 32'(life), 3);
        chk("restart_go", 32'(game_over), 0);
        chk("restart_f3", 32'(fire3_x), 3);
        chk("restart_f4", 32'(fire4_y), 14);

        // Win priority: park at (87,57), then step onto (88,56) as fire3 passes x=88.
        for (int n = 0; n < 2000 && !(m_cx == 87 && m_cy == 57 && m_mode == M_PLAY && m_fp[2] == 88); n++) begin
            bit br, bd, bc;
            br = 1'b0; bd = 1'b0; bc = 1'b0;
            if (m_mode == M_DEAD || m_mode == M_WON || m_mode == M_IDLE) bc = 1'b1;
            else if (m_cy < 57) bd = 1'b1;
            else if (m_cx < 87) br = 1'b1;
            if ((bd && danger(m_cx, m_cy + 1)) || (br && danger(m_cx + 1, m_cy))) begin
                bd = 1'b0;
                br = 1'b0;
            end
            do_tick(1'b0, br, 1'b0, bd, bc);
        end
        chk("park_x", 32'(char_x), 87);
        chk("park_y", 32'(char_y), 57);
        do_tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("goal_x", 32'(char_x), 88);
        chk("goal_y", 32'(char_y), 56);
        lb = m_life;
        do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("win_flag", 32'(win), 1);
        chk("win_life", 32'(life), lb);
        chk("win_cd", 32'(cooldown), 0);
        repeat (5) do_tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("win_frozen_x", 32'(char_x), 88);
        chk("win_frozen_y", 32'(char_y), 56);

        // Random play, biased toward the goal corner, with tick-low gaps.
        reset_dut();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) gap();
            do_tick($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6,
                    $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6,
                    $urandom_range(0, 31) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
